// File: rtl/acc_pkg.sv
// Shared accelerator datapath types: memory word and word address.
// Pure type definitions, no logic.
package acc_pkg;
  typedef logic [31:0] data_t;
  typedef logic [15:0] addr_t;
endpackage

// File: rtl/mem_burst_ctl_if.sv
// Core-side command/read/write channels plus controller-side ctl_* channel.
// The slave modport is the sequencer view; master is the core+memory view.
interface mem_burst_ctl_if #(
  parameter int LEN_W = 8
);
  import acc_pkg::*;

  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_write_i;
  addr_t            req_addr_i;
  logic [LEN_W-1:0] req_len_i;
  data_t            rd_data_o;
  logic             rd_valid_o;
  logic             rd_ready_i;
  data_t            wr_data_i;
  logic             wr_valid_i;
  logic             wr_ready_o;
  logic             busy_o;
  logic             done_o;
  logic             ctl_rden_o;
  addr_t            ctl_raddr_o;
  data_t            ctl_rdata_i;
  logic             ctl_rvalid_i;
  logic             ctl_wren_o;
  data_t            ctl_wdata_o;
  addr_t            ctl_waddr_o;
  logic             ctl_wready_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_len_i, rd_ready_i,
           wr_data_i, wr_valid_i, ctl_rdata_i, ctl_rvalid_i, ctl_wready_i,
    output req_ready_o, rd_data_o, rd_valid_o, wr_ready_o, busy_o, done_o,
           ctl_rden_o, ctl_raddr_o, ctl_wren_o, ctl_wdata_o, ctl_waddr_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_len_i, rd_ready_i,
           wr_data_i, wr_valid_i, ctl_rdata_i, ctl_rvalid_i, ctl_wready_i,
    input  req_ready_o, rd_data_o, rd_valid_o, wr_ready_o, busy_o, done_o,
           ctl_rden_o, ctl_raddr_o, ctl_wren_o, ctl_wdata_o, ctl_waddr_o
  );
endinterface

// File: rtl/mem_burst_ctl.sv
// Splits one read/write burst into single-word ctl_* requests; first request one cycle after accept.
// Reads are credit-limited by FIFO space (issued-but-unpopped <= FIFO_DEPTH); writes pass through under valid/ready.
module mem_burst_ctl #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  mem_burst_ctl_if.slave bus
);
  import acc_pkg::*;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t           state_q, state_d;
  addr_t            base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] pop_cnt_q, pop_cnt_d;
  logic [CW-1:0]    outst_q, outst_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  data_t            mem_q [FIFO_DEPTH];
  data_t            mem_d [FIFO_DEPTH];

  logic in_rd, in_wr, more, rd_vld, pop, push, fifo_full, issue, wren, wr_hs;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    pop_cnt_d = pop_cnt_q;
    outst_d   = outst_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_d     = mem_q;

    in_rd     = (state_q == S_RD);
    in_wr     = (state_q == S_WR);
    more      = (cnt_q < len_q);
    rd_vld    = in_rd && (count_q != '0);
    pop       = rd_vld && bus.rd_ready_i;
    fifo_full = (count_q == CW'(FIFO_DEPTH));
    push      = in_rd && bus.ctl_rvalid_i && (!fifo_full || pop);
    // Credit check counts words still in flight as already occupying the FIFO.
    issue     = in_rd && more &&
                (({1'b0, outst_q} + {1'b0, count_q}) < (CW+1)'(FIFO_DEPTH));
    wren      = in_wr && bus.wr_valid_i && more;
    wr_hs     = wren && bus.ctl_wready_i;

    if (issue || wr_hs) cnt_d = cnt_q + LEN_W'(1);
    if (push) begin
      mem_d[wptr_q] = bus.ctl_rdata_i;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d    = rptr_q + PW'(1);
      pop_cnt_d = pop_cnt_q + LEN_W'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (in_rd) outst_d = outst_q + CW'(issue) - CW'(bus.ctl_rvalid_i);

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          base_d    = bus.req_addr_i;
          len_d     = bus.req_len_i;
          cnt_d     = '0;
          pop_cnt_d = '0;
          outst_d   = '0;
          if (bus.req_len_i == '0) state_d = S_DONE;
          else if (bus.req_write_i) state_d = S_WR;
          else state_d = S_RD;
        end
      end
      S_RD:    if (pop && (pop_cnt_q == len_q - LEN_W'(1))) state_d = S_DONE;
      S_WR:    if (wr_hs && (cnt_q == len_q - LEN_W'(1))) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      pop_cnt_q <= '0;
      outst_q   <= '0;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      pop_cnt_q <= pop_cnt_d;
      outst_q   <= outst_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      mem_q     <= mem_d;
    end
  end

  assign bus.req_ready_o = (state_q == S_IDLE);
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.rd_valid_o  = rd_vld;
  assign bus.rd_data_o   = mem_q[rptr_q];
  assign bus.ctl_rden_o  = issue;
  assign bus.ctl_raddr_o = base_q + addr_t'(cnt_q);
  assign bus.ctl_wren_o  = wren;
  assign bus.ctl_wdata_o = in_wr ? bus.wr_data_i : '0;
  assign bus.ctl_waddr_o = base_q + addr_t'(cnt_q);
  assign bus.wr_ready_o  = in_wr && bus.ctl_wready_i && more;

  // A response arriving into a full FIFO with no pop is lost.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.ctl_rvalid_i && in_rd && fifo_full && !pop));

endmodule

// File: tb/tb_mem_burst_ctl.sv
// Directed bench for mem_burst_ctl with a fixed-latency memory responder.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_burst_ctl;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_burst_ctl_if #(.LEN_W(8)) bus();
  mem_burst_ctl #(.FIFO_DEPTH(4), .LEN_W(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  addr_t raddr_q[$];
  int    rden_cyc[$];
  data_t pop_q[$];
  int    pop_cyc[$];
  int    done_cyc[$];
  addr_t waddr_q[$];
  data_t wdata_q[$];
  int    whs_cyc[$];
  int    issued_tot, popped_tot, max_occ;

  logic  pipe_v [4];
  addr_t pipe_a [4];

  function automatic data_t mem_word(input addr_t a);
    return {16'hC0DE, a};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: request seen in cycle C answers in cycle C+lat.
  initial begin
    logic  cap_v;
    addr_t cap_a;
    for (int i = 0; i < 4; i++) begin pipe_v[i] = 1'b0; pipe_a[i] = '0; end
    forever begin
      @(negedge clk);
      cap_v = bus.ctl_rden_o;
      cap_a = bus.ctl_raddr_o;
      @(posedge clk);
      #1;
      for (int i = 3; i > 0; i--) begin pipe_v[i] = pipe_v[i-1]; pipe_a[i] = pipe_a[i-1]; end
      pipe_v[0] = cap_v;
      pipe_a[0] = cap_a;
      bus.ctl_rvalid_i = pipe_v[lat-1];
      bus.ctl_rdata_i  = pipe_v[lat-1] ? mem_word(pipe_a[lat-1]) : '0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.ctl_rden_o) begin
      raddr_q.push_back(bus.ctl_raddr_o); rden_cyc.push_back(cyc); issued_tot++;
    end
    if (bus.rd_valid_o && bus.rd_ready_i) begin
      pop_q.push_back(bus.rd_data_o); pop_cyc.push_back(cyc); popped_tot++;
    end
    if (bus.done_o) done_cyc.push_back(cyc);
    if (bus.ctl_wren_o && bus.ctl_wready_i) begin
      waddr_q.push_back(bus.ctl_waddr_o); wdata_q.push_back(bus.ctl_wdata_o); whs_cyc.push_back(cyc);
    end
    if (issued_tot - popped_tot > max_occ) max_occ = issued_tot - popped_tot;
  end

  task automatic clear_mon();
    raddr_q.delete(); rden_cyc.delete(); pop_q.delete(); pop_cyc.delete();
    done_cyc.delete(); waddr_q.delete(); wdata_q.delete(); whs_cyc.delete();
    issued_tot = 0; popped_tot = 0; max_occ = 0;
  endtask

  task automatic send_cmd(input bit wr, input addr_t a, input logic [7:0] len, output int t);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1; bus.req_write_i = wr; bus.req_addr_i = a; bus.req_len_i = len;
    t = -100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) begin t = cyc; break; end
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_cyc.size() > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bus.wr_data_i = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready_o); end
    total++; if ({bus.busy_o, bus.done_o, bus.rd_valid_o, bus.wr_ready_o, bus.ctl_rden_o, bus.ctl_wren_o} !== 6'b0) begin
      bad++; $display("FAIL rst_flags got=%b exp=000000",
        {bus.busy_o, bus.done_o, bus.rd_valid_o, bus.wr_ready_o, bus.ctl_rden_o, bus.ctl_wren_o}); end
    total++; if ({bus.ctl_raddr_o, bus.ctl_waddr_o, bus.ctl_wdata_o, bus.rd_data_o} !== '0) begin
      bad++; $display("FAIL rst_data raddr=%h waddr=%h wdata=%h rdata=%h exp=0",
        bus.ctl_raddr_o, bus.ctl_waddr_o, bus.ctl_wdata_o, bus.rd_data_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wr_data_i = '0;
  endtask

  task automatic test_read4();
    int t; bit ok;
    clear_mon(); lat = 1; bus.rd_ready_i = 1'b1;
    send_cmd(1'b0, 16'h0010, 8'd4, t);
    wait_done(40, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL read4_done_timeout got=none exp=pulse"); end
    total++; if (raddr_q.size() != 4) begin bad++; $display("FAIL read4_nreq got=%0d exp=4", raddr_q.size()); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= raddr_q.size() || raddr_q[k] !== addr_t'(16'h0010 + k) || rden_cyc[k] != t + 1 + k) begin
        bad++; $display("FAIL read4_req%0d got=%h@%0d exp=%h@%0d", k,
          (k < raddr_q.size()) ? raddr_q[k] : 16'hxxxx, (k < rden_cyc.size()) ? rden_cyc[k] : -1,
          16'h0010 + k, t + 1 + k);
      end
      total++;
      if (k >= pop_q.size() || pop_q[k] !== mem_word(addr_t'(16'h0010 + k))) begin
        bad++; $display("FAIL read4_beat%0d got=%h exp=%h", k,
          (k < pop_q.size()) ? pop_q[k] : 32'hxxxxxxxx, mem_word(addr_t'(16'h0010 + k)));
      end
    end
    total++; if (done_cyc.size() != 1 || done_cyc[0] != t + 7) begin
      bad++; $display("FAIL read4_done got=%0d pulses first=%0d exp=1 at %0d",
        done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 7); end
  endtask

  task automatic test_read_stall();
    int t; bit ok;
    clear_mon(); lat = 1; bus.rd_ready_i = 1'b0;
    send_cmd(1'b0, 16'h0040, 8'd8, t);
    repeat (15) @(negedge clk);
    total++; if (raddr_q.size() != 4) begin bad++; $display("FAIL stall_nreq got=%0d exp=4", raddr_q.size()); end
    total++; if (bus.rd_valid_o !== 1'b1) begin bad++; $display("FAIL stall_rd_valid got=%b exp=1", bus.rd_valid_o); end
    @(posedge clk); #1;
    bus.rd_ready_i = 1'b1;
    wait_done(60, ok);
    repeat (2) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL stall_done_timeout got=none exp=pulse"); end
    total++; if (raddr_q.size() != 8 || pop_q.size() != 8) begin
      bad++; $display("FAIL stall_counts got=%0d req %0d pops exp=8/8", raddr_q.size(), pop_q.size()); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (k >= pop_q.size() || k >= raddr_q.size() ||
          raddr_q[k] !== addr_t'(16'h0040 + k) || pop_q[k] !== mem_word(addr_t'(16'h0040 + k))) begin
        bad++; $display("FAIL stall_word%0d addr=%h data=%h exp=%h/%h", k,
          (k < raddr_q.size()) ? raddr_q[k] : 16'hxxxx, (k < pop_q.size()) ? pop_q[k] : 32'hxxxxxxxx,
          16'h0040 + k, mem_word(addr_t'(16'h0040 + k)));
      end
    end
    total++; if (max_occ > 4) begin bad++; $display("FAIL stall_credit got=%0d exp<=4", max_occ); end
    total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL stall_done_pulses got=%0d exp=1", done_cyc.size()); end
  endtask

  task automatic test_write();
    int t; int idx; bit ok;
    data_t d [3];
    logic [7:0] vpat;
    d[0] = 32'h1111_0001; d[1] = 32'h2222_0002; d[2] = 32'h3333_0003;
    vpat = 8'b0101_1011;
    clear_mon(); bus.wr_valid_i = 1'b0; bus.ctl_wready_i = 1'b0;
    send_cmd(1'b1, 16'h0020, 8'd3, t);
    idx = 0;
    for (int c = 0; c < 30 && idx < 3; c++) begin
      bus.wr_valid_i = vpat[c % 8]; bus.wr_data_i = d[idx]; bus.ctl_wready_i = (c % 2 == 0);
      @(negedge clk);
      if (bus.ctl_wren_o) begin
        total++;
        if (bus.ctl_wdata_o !== d[idx] || bus.ctl_waddr_o !== addr_t'(16'h0020 + idx)) begin
          bad++; $display("FAIL write_req%0d got=%h@%h exp=%h@%h", idx,
            bus.ctl_wdata_o, bus.ctl_waddr_o, d[idx], 16'h0020 + idx);
        end
      end
      if (bus.wr_valid_i && bus.wr_ready_o) idx++;
      @(posedge clk); #1;
    end
    bus.wr_valid_i = 1'b0; bus.ctl_wready_i = 1'b0;
    wait_done(20, ok);
    repeat (2) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL write_done_timeout got=none exp=pulse"); end
    total++; if (whs_cyc.size() != 3 || whs_cyc[0] != t + 1 || whs_cyc[1] != t + 5 || whs_cyc[2] != t + 7) begin
      bad++; $display("FAIL write_hs_cycles got=%0d hs first=%0d exp=3 at %0d,%0d,%0d",
        whs_cyc.size(), (whs_cyc.size() > 0) ? whs_cyc[0] : -1, t + 1, t + 5, t + 7); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (k >= waddr_q.size() || waddr_q[k] !== addr_t'(16'h0020 + k) || wdata_q[k] !== d[k]) begin
        bad++; $display("FAIL write_beat%0d got=%h@%h exp=%h@%h", k,
          (k < wdata_q.size()) ? wdata_q[k] : 32'hxxxxxxxx, (k < waddr_q.size()) ? waddr_q[k] : 16'hxxxx,
          d[k], 16'h0020 + k);
      end
    end
    total++; if (done_cyc.size() != 1 || done_cyc[0] != t + 8) begin
      bad++; $display("FAIL write_done got=%0d pulses first=%0d exp=1 at %0d",
        done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 8); end
  endtask

  task automatic test_len0();
    int t;
    for (int w = 0; w < 2; w++) begin
      clear_mon();
      bus.wr_valid_i = (w == 1); bus.ctl_wready_i = (w == 1); bus.rd_ready_i = 1'b1;
      send_cmd(w[0], 16'h0055, 8'd0, t);
      @(negedge clk);
      total++; if (bus.req_ready_o !== 1'b0 || bus.done_o !== 1'b1) begin
        bad++; $display("FAIL len0_%0d_t1 ready=%b done=%b exp=0/1", w, bus.req_ready_o, bus.done_o); end
      @(negedge clk);
      total++; if (bus.req_ready_o !== 1'b1 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        bad++; $display("FAIL len0_%0d_t2 ready=%b done=%b busy=%b exp=1/0/0", w, bus.req_ready_o, bus.done_o, bus.busy_o); end
      total++; if (issued_tot != 0 || waddr_q.size() != 0) begin
        bad++; $display("FAIL len0_%0d_noreq got=%0d rd %0d wr exp=0/0", w, issued_tot, waddr_q.size()); end
      total++; if (done_cyc.size() != 1 || done_cyc[0] != t + 1) begin
        bad++; $display("FAIL len0_%0d_done got=%0d first=%0d exp=1 at %0d", w, done_cyc.size(),
          (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 1); end
    end
    bus.wr_valid_i = 1'b0; bus.ctl_wready_i = 1'b0;
  endtask

  task automatic test_wrap();
    int t; bit ok;
    clear_mon(); lat = 1; bus.rd_ready_i = 1'b1;
    send_cmd(1'b0, 16'hFFFF, 8'd2, t);
    wait_done(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_done_timeout got=none exp=pulse"); end
    total++; if (raddr_q.size() != 2 || raddr_q[0] !== 16'hFFFF || raddr_q[1] !== 16'h0000) begin
      bad++; $display("FAIL wrap_addr got=%0d reqs first=%h exp=FFFF,0000", raddr_q.size(),
        (raddr_q.size() > 0) ? raddr_q[0] : 16'hxxxx); end
    total++; if (pop_q.size() != 2 || pop_q[0] !== 32'hC0DE_FFFF || pop_q[1] !== 32'hC0DE_0000) begin
      bad++; $display("FAIL wrap_data got=%0d beats first=%h exp=C0DEFFFF,C0DE0000", pop_q.size(),
        (pop_q.size() > 0) ? pop_q[0] : 32'hxxxxxxxx); end
  endtask

  task automatic test_reset_mid();
    int t; bit ok;
    clear_mon(); lat = 3; bus.rd_ready_i = 1'b1;
    send_cmd(1'b0, 16'h0080, 8'd6, t);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (issued_tot != 2) begin bad++; $display("FAIL midrst_inflight got=%0d exp=2", issued_tot); end
    total++; if (bus.req_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 ||
                 bus.ctl_rden_o !== 1'b0 || bus.rd_valid_o !== 1'b0 || bus.ctl_raddr_o !== 16'h0 ||
                 bus.rd_data_o !== 32'h0) begin
      bad++; $display("FAIL midrst_outputs ready=%b busy=%b done=%b rden=%b rvld=%b raddr=%h rdata=%h exp=1/0/0/0/0/0/0",
        bus.req_ready_o, bus.busy_o, bus.done_o, bus.ctl_rden_o, bus.rd_valid_o, bus.ctl_raddr_o, bus.rd_data_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.rd_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        bad++; $display("FAIL midrst_late%0d rvld=%b busy=%b exp=0/0", i, bus.rd_valid_o, bus.busy_o); end
    end
    total++; if (pop_q.size() != 0) begin bad++; $display("FAIL midrst_pops got=%0d exp=0", pop_q.size()); end
    clear_mon(); lat = 1;
    send_cmd(1'b0, 16'h0030, 8'd2, t);
    wait_done(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_next_timeout got=none exp=pulse"); end
    total++; if (raddr_q.size() != 2 || raddr_q[0] !== 16'h0030 || raddr_q[1] !== 16'h0031 || rden_cyc[0] != t + 1) begin
      bad++; $display("FAIL midrst_next_addr got=%0d reqs first=%h exp=0030,0031", raddr_q.size(),
        (raddr_q.size() > 0) ? raddr_q[0] : 16'hxxxx); end
    total++; if (pop_q.size() != 2 || pop_q[0] !== 32'hC0DE_0030 || pop_q[1] !== 32'hC0DE_0031) begin
      bad++; $display("FAIL midrst_next_data got=%0d beats first=%h exp=C0DE0030,C0DE0031", pop_q.size(),
        (pop_q.size() > 0) ? pop_q[0] : 32'hxxxxxxxx); end
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_addr_i = '0; bus.req_len_i = '0;
    bus.rd_ready_i = 1'b0; bus.wr_data_i = '0; bus.wr_valid_i = 1'b0;
    bus.ctl_rdata_i = '0; bus.ctl_rvalid_i = 1'b0; bus.ctl_wready_i = 1'b0;
    clear_mon();
    test_reset();
    test_read4();
    test_read_stall();
    test_write();
    test_len0();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
